// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared definitions for the tiny-tapeout style mux row.
//   state_t          selection FSM states
//   FLAG_ACT/GRD     bit positions of the status flags in spine_ow
//   u_ow_w/u_iw_w    per-UM output/input bundle widths
//   a_w              selection counter width (5 row bits + local index)
package tt_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GUARD  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam int FLAG_ACT = 0;
  localparam int FLAG_GRD = 1;
  localparam int FLAG_W   = 2;

  function automatic int u_ow_w(input int n_o, input int n_io);
    return n_o + 2 * n_io;
  endfunction

  function automatic int u_iw_w(input int n_i, input int n_io);
    return n_i + n_io;
  endfunction

  function automatic int a_w(input int n_um);
    return 5 + $clog2(n_um);
  endfunction

endpackage

// File: rtl/tt_mux_sel.sv
// tt_mux_sel: selection counter, row-hit decode and guard/active FSM.
//   clk, rst        clock, async active-high reset
//   sel_clr/inc     counter pulses (clear wins)
//   addr            row address strap
//   state_nxt       FSM next state (registered copies live in the top)
//   idx             local UM index of the current count
//   idx_nxt         local UM index of the next count
//
// state    | meaning
// S_IDLE   | row not selected, everything blanked
// S_GUARD  | blanking after a selection change, gcnt cycles remain
// S_ACTIVE | row hit, one UM enabled at the local index
module tt_mux_sel
  import tt_mux_pkg::*;
#(
  parameter int N_UM  = 16,
  parameter int GUARD = 2,
  localparam int A_W  = a_w(N_UM),
  localparam int L_W  = $clog2(N_UM)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel_clr,
  input  logic           sel_inc,
  input  logic [4:0]     addr,
  output state_t         state_nxt,
  output logic [L_W-1:0] idx,
  output logic [L_W-1:0] idx_nxt
);

  localparam logic [3:0] GUARD_LD = 4'(GUARD);

  state_t         state;
  logic [A_W-1:0] sel_cnt, sel_nxt;
  logic [3:0]     gcnt, gcnt_nxt;
  logic           hit, hit_nxt, changed;

  always_comb begin
    sel_nxt = sel_cnt;
    if (sel_clr)      sel_nxt = '0;
    else if (sel_inc) sel_nxt = sel_cnt + A_W'(1);
  end

  // A pulse that leaves the count unchanged (clear at 0) must not restart the guard.
  assign changed = (sel_nxt != sel_cnt);
  assign hit     = (sel_cnt[A_W-1 -: 5] == addr);
  assign hit_nxt = (sel_nxt[A_W-1 -: 5] == addr);
  assign idx     = sel_cnt[L_W-1:0];
  assign idx_nxt = sel_nxt[L_W-1:0];

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    if (changed) begin
      if (GUARD == 0) begin
        state_nxt = hit_nxt ? S_ACTIVE : S_IDLE;
        gcnt_nxt  = '0;
      end else begin
        state_nxt = S_GUARD;
        gcnt_nxt  = GUARD_LD;
      end
    end else begin
      case (state)
        S_GUARD: begin
          gcnt_nxt = gcnt - 4'd1;
          if (gcnt <= 4'd1) begin
            state_nxt = hit ? S_ACTIVE : S_IDLE;
            gcnt_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_cnt <= '0;
      state   <= S_IDLE;
      gcnt    <= '0;
    end else begin
      sel_cnt <= sel_nxt;
      state   <= state_nxt;
      gcnt    <= gcnt_nxt;
    end
  end

endmodule

// File: rtl/tt_mux_pipe.sv
// tt_mux_pipe: one mux row routing spine data to/from N_UM user modules.
//   clk, rst        clock, async active-high reset
//   um_ow/um_iw     UM output/input bundles, UM k at slice k*width
//   um_ena          registered one-hot enable of the active UM
//   um_k_zero       per-UM constant 0
//   spine_iw        spine input data (registered once toward the UMs)
//   spine_ow        {selected UM data, guard flag, active flag}
//   sel_clr/inc     selection counter pulses
//   addr            row address strap
//   k_zero/k_one    constants
module tt_mux_pipe
  import tt_mux_pkg::*;
#(
  parameter int N_UM    = 16,
  parameter int N_IO    = 8,
  parameter int N_O     = 8,
  parameter int N_I     = 10,
  parameter int GUARD   = 2,
  parameter int OUT_REG = 1,
  localparam int U_OW   = u_ow_w(N_O, N_IO),
  localparam int U_IW   = u_iw_w(N_I, N_IO),
  localparam int S_OW   = U_OW + FLAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [U_OW*N_UM-1:0] um_ow,
  output logic [U_IW*N_UM-1:0] um_iw,
  output logic [N_UM-1:0]      um_ena,
  output logic [N_UM-1:0]      um_k_zero,
  input  logic [U_IW-1:0]      spine_iw,
  output logic [S_OW-1:0]      spine_ow,
  input  logic                 sel_clr,
  input  logic                 sel_inc,
  input  logic [4:0]           addr,
  output logic                 k_zero,
  output logic                 k_one
);

  localparam int L_W = $clog2(N_UM);

  state_t          state_nxt;
  logic [L_W-1:0]  idx, idx_nxt;
  logic [N_UM-1:0] ena_q;
  logic [U_IW-1:0] iw_q;
  logic            act_q, grd_q;
  logic [U_OW-1:0] ow_sel, ow_data;

  tt_mux_sel #(.N_UM(N_UM), .GUARD(GUARD)) u_sel (
    .clk       (clk),
    .rst       (rst),
    .sel_clr   (sel_clr),
    .sel_inc   (sel_inc),
    .addr      (addr),
    .state_nxt (state_nxt),
    .idx       (idx),
    .idx_nxt   (idx_nxt)
  );

  // Enable and flags load from the next state so they track the FSM register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q <= '0;
      iw_q  <= '0;
      act_q <= 1'b0;
      grd_q <= 1'b0;
    end else begin
      ena_q <= (state_nxt == S_ACTIVE) ? (N_UM'(1) << idx_nxt) : '0;
      iw_q  <= spine_iw;
      act_q <= (state_nxt == S_ACTIVE);
      grd_q <= (state_nxt == S_GUARD);
    end
  end

  // The count is frozen while ACTIVE, so the current index selects the return data.
  assign ow_sel = um_ow[idx*U_OW +: U_OW];

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [U_OW-1:0] ow_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ow_q <= '0;
        else     ow_q <= ow_sel;
      end
      assign ow_data = ow_q;
    end else begin : g_out_comb
      assign ow_data = ow_sel;
    end
  endgenerate

  always_comb begin
    um_iw = '0;
    for (int k = 0; k < N_UM; k++) begin
      um_iw[k*U_IW +: U_IW] = ena_q[k] ? iw_q : '0;
    end
  end

  assign um_ena    = ena_q;
  assign spine_ow  = {(act_q ? ow_data : {U_OW{1'b0}}), grd_q, act_q};
  assign um_k_zero = '0;
  assign k_zero    = 1'b0;
  assign k_one     = 1'b1;

endmodule

// File: tb/tb_tt_mux_pipe.sv
module tb_tt_mux_pipe;

  logic          clk = 1'b0;
  logic          rst;
  logic [383:0]  um_ow;
  logic [17:0]   spine_iw;
  logic          sel_clr, sel_inc;
  logic [4:0]    addr;

  logic [287:0]  um_iw_a, um_iw_b;
  logic [15:0]   um_ena_a, um_ena_b, kz_a, kz_b;
  logic [25:0]   spine_ow_a, spine_ow_b;
  logic          k_zero_a, k_one_a, k_zero_b, k_one_b;

  int checks = 0;
  int errors = 0;
  logic [287:0] e_iw;

  always #5 clk = ~clk;

  tt_mux_pipe dut_a (
    .clk(clk), .rst(rst), .um_ow(um_ow), .um_iw(um_iw_a), .um_ena(um_ena_a),
    .um_k_zero(kz_a), .spine_iw(spine_iw), .spine_ow(spine_ow_a),
    .sel_clr(sel_clr), .sel_inc(sel_inc), .addr(addr),
    .k_zero(k_zero_a), .k_one(k_one_a)
  );

  tt_mux_pipe #(.GUARD(0), .OUT_REG(0)) dut_b (
    .clk(clk), .rst(rst), .um_ow(um_ow), .um_iw(um_iw_b), .um_ena(um_ena_b),
    .um_k_zero(kz_b), .spine_iw(spine_iw), .spine_ow(spine_ow_b),
    .sel_clr(sel_clr), .sel_inc(sel_inc), .addr(addr),
    .k_zero(k_zero_b), .k_one(k_one_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; um_ow = '0; spine_iw = '0; sel_clr = 1'b0; sel_inc = 1'b0; addr = 5'd3;
    #2;
    chk("rst_ena", um_ena_a, 16'h0);
    chk("rst_spine", spine_ow_a, 26'h0);
    chk("rst_iw", um_iw_a, 288'h0);
    chk("k_zero", k_zero_a, 1'b0);
    chk("k_one", k_one_a, 1'b1);
    chk("um_k_zero", kz_a, 16'h0);
    chk("rst_ena_b", um_ena_b, 16'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_flags", spine_ow_a[1:0], 2'b00);

    // clear at 0 is not a change
    sel_clr = 1'b1; tick(); sel_clr = 1'b0;
    chk("clr_nochg_grd", spine_ow_a[1:0], 2'b00);

    // 49 increments -> 0x31, row 3 local 1
    sel_inc = 1'b1;
    repeat (49) tick();
    sel_inc = 1'b0;
    chk("g1_flags", spine_ow_a[1:0], 2'b10);
    chk("g1_ena", um_ena_a, 16'h0);
    chk("b_ena_0x31", um_ena_b, 16'h0002);
    chk("b_act", spine_ow_b[1:0], 2'b01);
    tick();
    chk("g2_flags", spine_ow_a[1:0], 2'b10);
    tick();
    chk("act_ena", um_ena_a, 16'h0002);
    chk("act_flags", spine_ow_a[1:0], 2'b01);

    // data path at local index 1
    spine_iw = 18'h2A5;
    um_ow = '0; um_ow[24 +: 24] = 24'hABCDEF; um_ow[0 +: 24] = 24'h111111;
    #1;
    chk("b_ow_comb", spine_ow_b, {24'hABCDEF, 2'b01});
    chk("a_ow_lat", spine_ow_a, {24'h0, 2'b01});
    chk("a_iw_lat", um_iw_a, 288'h0);
    tick();
    e_iw = '0; e_iw[18 +: 18] = 18'h2A5;
    chk("a_iw", um_iw_a, e_iw);
    chk("b_iw", um_iw_b, e_iw);
    chk("a_ow", spine_ow_a, {24'hABCDEF, 2'b01});

    // clear wins over increment, and restarts guard
    addr = 5'd0;
    sel_clr = 1'b1; tick(); sel_clr = 1'b0;
    chk("clr_grd", spine_ow_a, {24'h0, 2'b10});
    chk("clr_b_ena", um_ena_b, 16'h0001);
    tick(); tick();
    chk("clr_act", um_ena_a, 16'h0001);
    sel_inc = 1'b1;
    repeat (5) tick();
    sel_clr = 1'b1;
    tick();
    sel_clr = 1'b0; sel_inc = 1'b0;
    chk("both_grd", spine_ow_a[1:0], 2'b10);
    chk("both_ena", um_ena_a, 16'h0);
    chk("both_b_ena", um_ena_b, 16'h0001);
    tick();
    chk("restart_grd", spine_ow_a[1:0], 2'b10);
    tick();
    chk("clr_wins", um_ena_a, 16'h0001);

    // wrap 0x1FF -> 0x000
    sel_inc = 1'b1;
    repeat (511) tick();
    chk("x1ff_grd", spine_ow_a[1:0], 2'b10);
    chk("x1ff_b", spine_ow_b, 26'h0);
    tick();
    sel_inc = 1'b0;
    chk("wrap_grd", spine_ow_a[1:0], 2'b10);
    chk("wrap_b_ena", um_ena_b, 16'h0001);
    tick(); tick();
    chk("wrap_ena", um_ena_a, 16'h0001);
    chk("wrap_act", spine_ow_a[1:0], 2'b01);

    // async reset mid-ACTIVE
    um_ow = '0; um_ow[0 +: 24] = 24'h123456;
    tick();
    chk("pre_rst_ow", spine_ow_a, {24'h123456, 2'b01});
    #3 rst = 1'b1;
    #1;
    chk("arst_ena", um_ena_a, 16'h0);
    chk("arst_spine", spine_ow_a, 26'h0);
    chk("arst_iw", um_iw_a, 288'h0);
    chk("arst_b_ena", um_ena_b, 16'h0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_idle", spine_ow_a[1:0], 2'b00);
    chk("post_rst_ena", um_ena_a, 16'h0);
    chk("post_rst_b", spine_ow_b, 26'h0);
    sel_inc = 1'b1; tick(); sel_inc = 1'b0;
    chk("post_inc_grd", spine_ow_a[1:0], 2'b10);
    chk("post_inc_b_ena", um_ena_b, 16'h0002);
    um_ow = '0; um_ow[24 +: 24] = 24'h654321;
    #1;
    chk("b_ow_follow", spine_ow_b, {24'h654321, 2'b01});
    tick(); tick();
    chk("post_inc_ena", um_ena_a, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
